// File: rtl/neg_share_arbiter.sv
// neg_share_arbiter: round-robin burst arbiter sharing one registered extend/negate stage between requesters A and B
module neg_share_arbiter #(
  parameter int BW_IN     = 32,
  parameter int BW_OUT    = 32,
  parameter int IN_SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              neg_en,
  input  logic              a_valid,
  input  logic [BW_IN-1:0]  a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [BW_IN-1:0]  b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [BW_OUT-1:0] out_data,
  output logic              out_src,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  logic [1:0]        state;
  logic              rr_last;
  logic              mode_q;
  logic              can_acc;
  logic              xfer;
  logic              sel_last;
  logic [BW_IN-1:0]  sel_data;
  logic [BW_OUT-1:0] ext;
  assign can_acc  = !out_valid || out_ready;
  assign a_ready  = (state == GNT_A) && can_acc;
  assign b_ready  = (state == GNT_B) && can_acc;
  assign busy     = state != IDLE;
  assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
  assign sel_data = (state == GNT_B) ? b_data : a_data;
  assign sel_last = (state == GNT_B) ? b_last : a_last;
  generate
    if (BW_IN < BW_OUT) begin : g_ext
      assign ext = {{(BW_OUT-BW_IN){(IN_SIGNED != 0) && sel_data[BW_IN-1]}}, sel_data};
    end else begin : g_trunc
      assign ext = sel_data[BW_OUT-1:0];
    end
  endgenerate
  // rr_last names the requester that most recently finished a burst; ties go to the other one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (a_valid && (!b_valid || rr_last)) begin
          state  <= GNT_A;
          mode_q <= neg_en;
        end else if (b_valid) begin
          state  <= GNT_B;
          mode_q <= neg_en;
        end
      end else if (xfer && sel_last) begin
        state   <= IDLE;
        rr_last <= state == GNT_B;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mode_q ? -ext : ext;
        out_src   <= state == GNT_B;
        out_last  <= sel_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_neg_share_arbiter.sv
// tb_neg_share_arbiter: directed checks of arbitration, extend/negate, backpressure and reset
module tb_neg_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic neg_en, out_ready;
  logic a_valid, a_last, a_ready, b_valid, b_last, b_ready;
  logic [7:0] a_data, b_data;
  logic out_valid, out_src, out_last, busy;
  logic [15:0] out_data;
  logic u_valid, u_last, u_ready, u_bready, u_ov, u_os, u_ol, u_busy;
  logic [7:0] u_data;
  logic [15:0] u_od;
  logic t_valid, t_last, t_ready, t_bready, t_ov, t_os, t_ol, t_busy;
  logic [31:0] t_data;
  logic [15:0] t_od;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  neg_share_arbiter #(.BW_IN(8), .BW_OUT(16), .IN_SIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .neg_en(neg_en),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .busy(busy));

  neg_share_arbiter #(.BW_IN(8), .BW_OUT(16), .IN_SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .neg_en(neg_en),
    .a_valid(u_valid), .a_data(u_data), .a_last(u_last), .a_ready(u_ready),
    .b_valid(1'b0), .b_data(8'h00), .b_last(1'b0), .b_ready(u_bready),
    .out_valid(u_ov), .out_data(u_od), .out_src(u_os), .out_last(u_ol),
    .out_ready(1'b1), .busy(u_busy));

  neg_share_arbiter #(.BW_IN(32), .BW_OUT(16), .IN_SIGNED(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .neg_en(neg_en),
    .a_valid(t_valid), .a_data(t_data), .a_last(t_last), .a_ready(t_ready),
    .b_valid(1'b0), .b_data(32'h0), .b_last(1'b0), .b_ready(t_bready),
    .out_valid(t_ov), .out_data(t_od), .out_src(t_os), .out_last(t_ol),
    .out_ready(1'b1), .busy(t_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; neg_en = 1'b0; out_ready = 1'b1;
    a_valid = 0; a_data = 0; a_last = 0; b_valid = 0; b_data = 0; b_last = 0;
    u_valid = 0; u_data = 0; u_last = 0; t_valid = 0; t_data = 0; t_last = 0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    rst_n = 1'b1;
    // T1: signed 0x80 negated
    a_valid = 1; a_data = 8'h80; a_last = 1; neg_en = 1;
    #1 chk("t1_a_ready_idle", a_ready, 0);
    tick();
    chk("t1_busy_grant", busy, 1);
    chk("t1_a_ready", a_ready, 1);
    tick();
    a_valid = 0; neg_en = 0;
    #1 chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 16'h0080);
    chk("t1_out_src", out_src, 0);
    chk("t1_out_last", out_last, 1);
    chk("t1_busy_done", busy, 0);
    // T2/T3: unsigned extension and truncation
    u_valid = 1; u_data = 8'hFF; u_last = 1;
    t_valid = 1; t_data = 32'h0001_0005; t_last = 1; neg_en = 1;
    tick(); tick();
    t_valid = 0; neg_en = 0;
    #1 chk("t2_neg_ff", u_od, 16'hFF01);
    chk("t3_trunc_neg", t_od, 16'hFFFB);
    tick(); tick();
    u_valid = 0;
    #1 chk("t2_pass_ff", u_od, 16'h00FF);
    chk("t2_pass_valid", u_ov, 1);
    t_valid = 1; t_data = 32'h0000_8000; neg_en = 1;
    tick(); tick();
    t_valid = 0; neg_en = 0;
    #1 chk("t3_wrap", t_od, 16'h8000);
    // T4: simultaneous requests after reset, round-robin
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_valid = 1; a_data = 8'h01; a_last = 0; b_valid = 1; b_data = 8'h11; b_last = 0;
    tick();
    #1 chk("t4_a_first", a_ready, 1);
    chk("t4_b_wait", b_ready, 0);
    tick();
    a_data = 8'h02;
    #1 chk("t4_w1", out_data, 16'h0001);
    tick();
    a_data = 8'h03; a_last = 1;
    #1 chk("t4_w2", out_data, 16'h0002);
    tick();
    a_data = 8'h04; a_last = 0; neg_en = 1;
    #1 chk("t4_w3", out_data, 16'h0003);
    chk("t4_w3_last", out_last, 1);
    chk("t4_bubble_busy", busy, 0);
    chk("t4_bubble_a_ready", a_ready, 0);
    tick();
    neg_en = 0;
    #1 chk("t4_b_next", b_ready, 1);
    chk("t4_a_blocked", a_ready, 0);
    chk("t4_bubble_out_valid", out_valid, 0);
    tick();
    b_data = 8'h12; b_last = 1;
    #1 chk("t4_b_w1", out_data, 16'hFFEF);
    chk("t4_b_src", out_src, 1);
    tick();
    b_valid = 0;
    #1 chk("t4_b_w2_mode_held", out_data, 16'hFFEE);
    chk("t4_b_last", out_last, 1);
    tick();
    #1 chk("t4_a_regrant", a_ready, 1);
    // T5: backpressure holds outputs
    tick();
    out_ready = 0; a_data = 8'h05;
    #1 chk("t5_w4", out_data, 16'h0004);
    chk("t5_stall_ready", a_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_data", out_data, 16'h0004);
      chk("t5_hold_src", out_src, 0);
      chk("t5_hold_last", out_last, 0);
      chk("t5_hold_ready", a_ready, 0);
    end
    out_ready = 1;
    #1 chk("t5_release_ready", a_ready, 1);
    tick();
    #1 chk("t5_w5", out_data, 16'h0005);
    // T6: reset mid-burst
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_valid = 1; a_data = 8'h21; a_last = 0;
    tick(); tick();
    a_data = 8'h22;
    tick();
    a_data = 8'h23;
    #1 chk("t6_w2", out_data, 16'h0022);
    rst_n = 1'b0; a_data = 8'h21;
    #1 chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_a_ready", a_ready, 0);
    #1 rst_n = 1'b1;
    #1 chk("t6_bubble_ready", a_ready, 0);
    tick();
    chk("t6_regrant", a_ready, 1);
    tick();
    #1 chk("t6_restart_w1", out_data, 16'h0021);
    chk("t6_restart_valid", out_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
